hazard_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage hazard unit for the RV32I 5-stage pipeline.
- Replaces fixed EX/MEM and MEM/WB rd comparisons with a per-register countdown scoreboard. Result latency is set separately for loads and ALU ops.
- Stalls on a busy multicycle unit, holds fetch for a configurable branch shadow, and keeps a saturating stall-cycle counter.
- Sits in ID and drives PC load, IF/ID load and the bubble mux (mux5).

---
 rtl/hazard_scoreboard_pkg.sv | 79 +++++++
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard_regfile.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Purpose : shared definitions for the ID-stage hazard scoreboard of the RV32I
//           5-stage pipeline: opcode constants, opcode decode helpers and a
//           width helper for the countdown registers.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

    // RV32I major opcodes that matter for hazard tracking.
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_branch;
        logic is_load;
    } decode_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_SB, OP_LOAD, OP_IALU, OP_JALR: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_SB: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_LOAD, OP_IALU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [6:0] op);
        case (op)
            OP_SB, OP_JAL, OP_JALR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return (op == OP_LOAD);
    endfunction

    function automatic decode_t decode(input logic [6:0] op);
        decode_t d;
        d.uses_rs1  = uses_rs1(op);
        d.uses_rs2  = uses_rs2(op);
        d.writes_rd = writes_rd(op);
        d.is_branch = is_branch(op);
        d.is_load   = is_load(op);
        return d;
    endfunction

    // Bits needed to hold a countdown of max(a,b); never less than one bit so
    // that a zero latency / zero depth still yields a legal vector.
    function automatic int cnt_width(input int a, input int b);
        int max_v;
        max_v = (a > b) ? a : b;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : bundle of the ID-stage signals seen by the hazard scoreboard.
// Signals : id_valid, opcode, rs1, rs2, rd, ex_busy   (ID stage -> scoreboard)
//           pc_load, if_id_load, mux5_selector,
//           stall_count                               (scoreboard -> pipeline)
// Modports: master = ID stage / pipeline side, slave = scoreboard.
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [6:0]             opcode;
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [REG_W-1:0]       rd;
    logic                   ex_busy;
    logic                   pc_load;
    logic                   if_id_load;
    logic                   mux5_selector;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, opcode, rs1, rs2, rd, ex_busy,
        input  pc_load, if_id_load, mux5_selector, stall_count
    );

    modport slave (
        input  id_valid, opcode, rs1, rs2, rd, ex_busy,
        output pc_load, if_id_load, mux5_selector, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
// Purpose : per-register countdown array. Every nonzero entry decrements each
//           clock; a set overrides the decrement on its entry. x0 and indices
//           beyond NUM_REGS have no storage and always read idle.
// Ports   : clock, reset           clock and synchronous active-high reset
//           i_set_en/idx/val       load one entry with a latency
//           i_rd_idx_a/b           combinational read indices
//           o_busy_a/b             1 when the addressed entry is nonzero
// -----------------------------------------------------------------------------
module scoreboard_regfile #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic [CNT_W-1:0] i_set_val,
    input  logic [REG_W-1:0] i_rd_idx_a,
    input  logic [REG_W-1:0] i_rd_idx_b,
    output logic             o_busy_a,
    output logic             o_busy_b
);
    localparam int DEPTH = 2 ** REG_W;

    // One busy bit per addressable index so reads never go out of range.
    logic [DEPTH-1:0] w_busy;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0 || gi >= NUM_REGS) begin : g_none
                assign w_busy[gi] = 1'b0;
            end else begin : g_cnt
                logic [CNT_W-1:0] r_cnt;
                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else if (i_set_en && i_set_idx == REG_W'(gi)) begin
                        r_cnt <= i_set_val;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                assign w_busy[gi] = (r_cnt != '0);
            end
        end
    endgenerate

    // Reads see the pre-edge value, so a same-cycle reload is not visible.
    assign o_busy_a = w_busy[i_rd_idx_a];
    assign o_busy_b = w_busy[i_rd_idx_b];
endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : ID-stage hazard unit. Tracks outstanding register writes with a
//           countdown scoreboard, holds on a busy multicycle unit, holds fetch
//           for a branch shadow and counts stalled valid cycles (saturating).
// Ports   : clock        pipeline clock, rising edge
//           reset        synchronous, active-high; forces hold outputs
//           bus (slave)  id_valid/opcode/rs1/rs2/rd/ex_busy in,
//                        pc_load/if_id_load/mux5_selector/stall_count out
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int ALU_LAT      = 3,
    parameter int LOAD_LAT     = 3,
    parameter int BRANCH_DEPTH = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);
    localparam int CNT_W = cnt_width(ALU_LAT, LOAD_LAT);
    localparam int SH_W  = cnt_width(BRANCH_DEPTH, 0);

    decode_t                w_dec;
    logic                   w_busy_rs1;
    logic                   w_busy_rs2;
    logic                   w_data_hazard;
    logic                   w_shadow_active;
    logic                   w_hold;
    logic                   w_issue;
    logic                   w_set_en;
    logic [CNT_W-1:0]       w_set_val;

    logic [SH_W-1:0]        r_shadow;
    logic [STALL_CNT_W-1:0] r_stall_count;

    assign w_dec = decode(bus.opcode);

    scoreboard_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .CNT_W    (CNT_W)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .i_set_en   (w_set_en),
        .i_set_idx  (bus.rd),
        .i_set_val  (w_set_val),
        .i_rd_idx_a (bus.rs1),
        .i_rd_idx_b (bus.rs2),
        .o_busy_a   (w_busy_rs1),
        .o_busy_b   (w_busy_rs2)
    );

    assign w_data_hazard = bus.id_valid &&
                           ((w_dec.uses_rs1 && bus.rs1 != '0 && w_busy_rs1) ||
                            (w_dec.uses_rs2 && bus.rs2 != '0 && w_busy_rs2));

    assign w_shadow_active = (r_shadow != '0);
    assign w_hold          = w_data_hazard || bus.ex_busy || w_shadow_active;
    assign w_issue         = bus.id_valid && !w_hold;

    assign w_set_en  = w_issue && w_dec.writes_rd && (bus.rd != '0);
    assign w_set_val = w_dec.is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

    // A branch in ID stops the PC immediately but still lets IF/ID advance;
    // the shadow counter then covers the following cycles.
    assign bus.pc_load       = !reset && !(w_hold || (bus.id_valid && w_dec.is_branch));
    assign bus.if_id_load    = !reset && !w_hold;
    assign bus.mux5_selector = reset || w_hold;
    assign bus.stall_count   = r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_issue && w_dec.is_branch) begin
            r_shadow <= SH_W'(BRANCH_DEPTH);
        end else if (w_shadow_active) begin
            r_shadow <= r_shadow - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (bus.id_valid && w_hold && r_stall_count != '1) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Two scoreboards with different latency settings share one stimulus stream.
// A model based on "cycle at which a register becomes free" predicts every
// output every cycle; directed literal checks pin the model on key scenarios,
// then a randomized phase exercises the rest.
//   A: ALU_LAT=3 LOAD_LAT=4 BRANCH_DEPTH=2 STALL_CNT_W=16
//   B: ALU_LAT=1 LOAD_LAT=4 BRANCH_DEPTH=0 STALL_CNT_W=3
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    logic       v_valid = 1'b0;
    logic [6:0] v_op    = 7'h00;
    logic [4:0] v_rs1   = 5'd0;
    logic [4:0] v_rs2   = 5'd0;
    logic [4:0] v_rd    = 5'd0;
    logic       v_busy  = 1'b0;

    hazard_scoreboard_if #(.REG_W(5), .STALL_CNT_W(16)) bus_a ();
    hazard_scoreboard_if #(.REG_W(5), .STALL_CNT_W(3))  bus_b ();

    assign bus_a.id_valid = v_valid;
    assign bus_a.opcode   = v_op;
    assign bus_a.rs1      = v_rs1;
    assign bus_a.rs2      = v_rs2;
    assign bus_a.rd       = v_rd;
    assign bus_a.ex_busy  = v_busy;
    assign bus_b.id_valid = v_valid;
    assign bus_b.opcode   = v_op;
    assign bus_b.rs1      = v_rs1;
    assign bus_b.rs2      = v_rs2;
    assign bus_b.rd       = v_rd;
    assign bus_b.ex_busy  = v_busy;

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_W(5), .ALU_LAT(3), .LOAD_LAT(4),
        .BRANCH_DEPTH(2), .STALL_CNT_W(16)
    ) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_W(5), .ALU_LAT(1), .LOAD_LAT(4),
        .BRANCH_DEPTH(0), .STALL_CNT_W(3)
    ) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    int     m_alu  [2] = '{3, 1};
    int     m_load [2] = '{4, 4};
    int     m_bd   [2] = '{2, 0};
    int     m_smax [2] = '{65535, 7};
    longint cyc = 0;
    longint ready_at [2][32];   // first cycle in which the register is free
    longint shadow_until [2];   // first cycle with no branch shadow
    int     m_stall [2];
    bit     m_hold_now [2];
    bit     started = 1'b0;

    function automatic bit f_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63, 7'h03, 7'h13, 7'h67};
    endfunction
    function automatic bit f_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction
    function automatic bit f_wr(input logic [6:0] op);
        return op inside {7'h33, 7'h03, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction
    function automatic bit f_br(input logic [6:0] op);
        return op inside {7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic bit m_hold(input int k);
        bit haz;
        haz = v_valid && ((f_rs1(v_op) && v_rs1 != 0 && ready_at[k][v_rs1] > cyc) ||
                          (f_rs2(v_op) && v_rs2 != 0 && ready_at[k][v_rs2] > cyc));
        return haz || v_busy || (shadow_until[k] > cyc);
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
            shadow_until[k] = 0;
            m_stall[k]      = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
                    shadow_until[k] = 0;
                    m_stall[k]      = 0;
                end else begin
                    m_hold_now[k] = m_hold(k);
                    if (v_valid && m_hold_now[k] && m_stall[k] < m_smax[k])
                        m_stall[k] = m_stall[k] + 1;
                    if (v_valid && !m_hold_now[k]) begin
                        if (f_wr(v_op) && v_rd != 0)
                            ready_at[k][v_rd] = cyc + ((v_op == 7'h03) ? m_load[k] : m_alu[k]) + 1;
                        if (f_br(v_op))
                            shadow_until[k] = cyc + m_bd[k] + 1;
                    end
                end
            end
            cyc     = cyc + 1;
            started = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                bit h;
                int a_pc, a_ifid, a_mux, a_stall;
                h       = m_hold(k);
                a_pc    = (k == 0) ? int'(bus_a.pc_load)       : int'(bus_b.pc_load);
                a_ifid  = (k == 0) ? int'(bus_a.if_id_load)    : int'(bus_b.if_id_load);
                a_mux   = (k == 0) ? int'(bus_a.mux5_selector) : int'(bus_b.mux5_selector);
                a_stall = (k == 0) ? int'(bus_a.stall_count)   : int'(bus_b.stall_count);
                check($sformatf("model.%s.pc_load", k == 0 ? "A" : "B"), a_pc,
                      int'(!rst && !(h || (v_valid && f_br(v_op)))));
                check($sformatf("model.%s.if_id_load", k == 0 ? "A" : "B"), a_ifid,
                      int'(!rst && !h));
                check($sformatf("model.%s.mux5_selector", k == 0 ? "A" : "B"), a_mux,
                      int'(rst || h));
                check($sformatf("model.%s.stall_count", k == 0 ? "A" : "B"), a_stall,
                      m_stall[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ins(input bit valid, input logic [6:0] op, input int r1,
                           input int r2, input int d, input bit busy, input string label);
        v_valid = valid;
        v_op    = op;
        v_rs1   = 5'(r1);
        v_rs2   = 5'(r2);
        v_rd    = 5'(d);
        v_busy  = busy;
        $display("[TB] cycle %0d: %s (valid=%0d op=%h rs1=%0d rs2=%0d rd=%0d busy=%0d)",
                 cyc, label, valid, op, r1, r2, d, busy);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] op_pool [10] = '{7'h33, 7'h23, 7'h63, 7'h03, 7'h13,
                                 7'h67, 7'h6F, 7'h37, 7'h17, 7'h0F};

    initial begin
        // Reset: outputs forced to hold.
        repeat (2) next();
        @(negedge clk);
        check("reset.A.pc_load", int'(bus_a.pc_load), 0);
        check("reset.A.mux5", int'(bus_a.mux5_selector), 1);
        check("reset.B.if_id_load", int'(bus_b.if_id_load), 0);
        next();
        rst = 1'b0;

        // ALU producer then dependent consumer: 3 stall cycles on A.
        set_ins(1, 7'h33, 1, 2, 5, 0, "add x5,x1,x2");
        @(negedge clk);
        check("t1.A.pc_load_first", int'(bus_a.pc_load), 1);
        next();
        set_ins(1, 7'h33, 5, 1, 6, 0, "add x6,x5,x1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1.A.mux5_stall", int'(bus_a.mux5_selector), 1);
            check("t1.A.pc_load_stall", int'(bus_a.pc_load), 0);
            next();
        end
        @(negedge clk);
        check("t1.A.mux5_issue", int'(bus_a.mux5_selector), 0);
        check("t1.A.pc_load_issue", int'(bus_a.pc_load), 1);
        check("t1.A.stall_count", int'(bus_a.stall_count), 3);
        next();

        // Branch shadow on A (depth 2).
        set_ins(1, 7'h63, 0, 0, 0, 0, "beq x0,x0");
        @(negedge clk);
        check("t4.A.pc_load_branch", int'(bus_a.pc_load), 0);
        check("t4.A.if_id_load_branch", int'(bus_a.if_id_load), 1);
        check("t4.A.mux5_branch", int'(bus_a.mux5_selector), 0);
        next();
        set_ins(1, 7'h33, 0, 0, 9, 0, "add x9,x0,x0");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4.A.mux5_shadow", int'(bus_a.mux5_selector), 1);
            check("t4.A.if_id_load_shadow", int'(bus_a.if_id_load), 0);
            check("t4.A.pc_load_shadow", int'(bus_a.pc_load), 0);
            next();
        end
        @(negedge clk);
        check("t4.A.mux5_after", int'(bus_a.mux5_selector), 0);
        check("t4.A.pc_load_after", int'(bus_a.pc_load), 1);
        next();

        // x0 destination and x0 sources never stall.
        set_ins(1, 7'h33, 0, 0, 0, 0, "add x0,x0,x0");
        @(negedge clk);
        check("t3.A.mux5_x0_write", int'(bus_a.mux5_selector), 0);
        next();
        set_ins(1, 7'h33, 0, 0, 11, 0, "add x11,x0,x0");
        @(negedge clk);
        check("t3.A.mux5_x0_read", int'(bus_a.mux5_selector), 0);
        next();

        // ex_busy holds for 5 cycles while counters drain.
        set_ins(1, 7'h33, 0, 0, 10, 0, "add x10,x0,x0");
        next();
        set_ins(1, 7'h33, 1, 2, 12, 1, "add x12,x1,x2 with ex_busy");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5.A.mux5_busy", int'(bus_a.mux5_selector), 1);
            check("t5.A.pc_load_busy", int'(bus_a.pc_load), 0);
            next();
        end
        set_ins(1, 7'h33, 10, 10, 13, 0, "add x13,x10,x10");
        @(negedge clk);
        check("t5.A.mux5_drained", int'(bus_a.mux5_selector), 0);
        next();

        // Reset in the middle of a stall.
        set_ins(1, 7'h33, 0, 0, 5, 0, "add x5,x0,x0");
        next();
        set_ins(1, 7'h33, 5, 0, 14, 0, "add x14,x5,x0");
        next();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6.A.pc_load_reset", int'(bus_a.pc_load), 0);
            check("t6.A.if_id_load_reset", int'(bus_a.if_id_load), 0);
            check("t6.A.mux5_reset", int'(bus_a.mux5_selector), 1);
            next();
        end
        rst = 1'b0;
        @(negedge clk);
        check("t6.A.mux5_released", int'(bus_a.mux5_selector), 0);
        check("t6.A.stall_cleared", int'(bus_a.stall_count), 0);
        check("t6.B.stall_cleared", int'(bus_b.stall_count), 0);
        next();

        // Load latency 4 and ALU latency 1 on B.
        set_ins(1, 7'h03, 0, 0, 7, 0, "lw x7");
        next();
        set_ins(1, 7'h23, 0, 7, 0, 0, "sw x7");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2.B.mux5_load_stall", int'(bus_b.mux5_selector), 1);
            next();
        end
        @(negedge clk);
        check("t2.B.mux5_load_issue", int'(bus_b.mux5_selector), 0);
        next();
        set_ins(1, 7'h33, 0, 0, 8, 0, "add x8,x0,x0");
        next();
        set_ins(1, 7'h33, 8, 0, 15, 0, "add x15,x8,x0");
        @(negedge clk);
        check("t2.B.mux5_alu_stall", int'(bus_b.mux5_selector), 1);
        next();
        @(negedge clk);
        check("t2.B.mux5_alu_issue", int'(bus_b.mux5_selector), 0);
        check("t2.A.mux5_alu_still", int'(bus_a.mux5_selector), 1);
        repeat (2) next();

        // Saturation of the 3-bit stall counter on B.
        set_ins(1, 7'h33, 0, 0, 16, 1, "add x16 held by ex_busy x10");
        repeat (10) next();
        @(negedge clk);
        check("t6.B.stall_saturated", int'(bus_b.stall_count), 7);
        set_ins(0, 7'h00, 0, 0, 0, 0, "idle");
        next();

        // Randomized phase, checked every cycle by the model.
        $display("[TB] cycle %0d: randomized phase, 3000 cycles", cyc);
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            v_valid = ($urandom_range(0, 99) < 85);
            v_op    = op_pool[$urandom_range(0, 9)];
            v_rs1   = 5'($urandom_range(0, 7));
            v_rs2   = 5'($urandom_range(0, 7));
            v_rd    = 5'($urandom_range(0, 7));
            v_busy  = ($urandom_range(0, 99) < 10);
            next();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
